// File: rtl/ctrl_bubble_stage.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_bubble_stage
// Description : ID/EX control-word register with load-use bubble injection.
//               A hazard in IDLE loads NOP_WORD for BUBBLE_CYCLES edges while
//               hold_up freezes IF/ID. Branch flush kills the entering word;
//               downstream stall freezes the whole stage.
//               Optional macro BUBBLE_CNT_EN adds a 16-bit saturating count
//               of inserted bubbles on port bubble_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_bubble_stage #(
    parameter int                CTRL_W        = 10,
    parameter int                BUBBLE_CYCLES = 1,
    parameter logic [CTRL_W-1:0] NOP_WORD      = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              in_valid,
    input  logic              hazard,
    input  logic              flush,
    input  logic              stall,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              out_valid,
`ifdef BUBBLE_CNT_EN
    output logic [15:0]       bubble_cnt,
`endif
    output logic              hold_up
);

    // Bubbles still owed after the one loaded by the hazard edge itself.
    localparam logic [3:0] c_REM_INIT = 4'(BUBBLE_CYCLES - 1);
    localparam bit         c_MULTI    = (BUBBLE_CYCLES > 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [3:0]        r_remaining;
    logic [3:0]        w_remainingNext;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CTRL_W-1:0] w_ctrlNext;
    logic              r_valid;
    logic              w_validNext;

    // State, remaining-bubble counter and the control register itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= 4'd0;
            r_ctrl      <= NOP_WORD;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_remaining <= w_remainingNext;
            r_ctrl      <= w_ctrlNext;
            r_valid     <= w_validNext;
        end
    end

    // Next-state selection: flush > stall > bubble window > hazard > load.
    always_comb begin
        w_stateNext     = r_state;
        w_remainingNext = r_remaining;
        w_ctrlNext      = r_ctrl;
        w_validNext     = r_valid;
        if (flush) begin
            w_stateNext     = ST_IDLE;
            w_remainingNext = 4'd0;
            w_ctrlNext      = NOP_WORD;
            w_validNext     = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (r_state == ST_BUBBLE) begin
            w_ctrlNext  = NOP_WORD;
            w_validNext = 1'b0;
            if (r_remaining != 4'd0) begin
                w_remainingNext = r_remaining - 4'd1;
            end
            if (r_remaining <= 4'd1) begin
                w_stateNext = ST_IDLE;
            end
        end else if (hazard) begin
            w_ctrlNext  = NOP_WORD;
            w_validNext = 1'b0;
            if (c_MULTI) begin
                w_stateNext     = ST_BUBBLE;
                w_remainingNext = c_REM_INIT;
            end else begin
                w_stateNext     = ST_IDLE;
                w_remainingNext = 4'd0;
            end
        end else begin
            w_ctrlNext  = ctrl_in;
            w_validNext = in_valid;
        end
    end

    assign ctrl_out  = r_ctrl;
    assign out_valid = r_valid;
    assign hold_up   = stall | (r_state == ST_BUBBLE)
                     | ((r_state == ST_IDLE) & hazard & ~flush);

`ifdef BUBBLE_CNT_EN
    logic [15:0] r_bubbleCnt;
    logic        w_countBubble;

    // A bubble is counted on every edge that loads a bubble (not a flush NOP).
    assign w_countBubble = ~flush & ~stall & ((r_state == ST_BUBBLE) | hazard);

    // Saturating bubble counter; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubbleCnt <= 16'd0;
        end else if (w_countBubble && (r_bubbleCnt != 16'hFFFF)) begin
            r_bubbleCnt <= r_bubbleCnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubbleCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_bubble_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_bubble_stage
// Description : Bench for ctrl_bubble_stage. Three instances (BUBBLE_CYCLES
//               1, 2, 3) share one stimulus stream and are compared with a
//               bubble-debt reference model, a directed vector table and
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_bubble_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] ctrlIn;
    logic       inValid, hazard, flush, stall;
    logic [9:0] ctrlOut [3];
    logic       outValid [3];
    logic       holdUp [3];
`ifdef BUBBLE_CNT_EN
    logic [15:0] bubbleCnt [3];
`endif

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < 3; k++) begin : g_dut
            ctrl_bubble_stage #(
                .CTRL_W       (10),
                .BUBBLE_CYCLES(k + 1),
                .NOP_WORD     (10'h000)
            ) dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .ctrl_in   (ctrlIn),
                .in_valid  (inValid),
                .hazard    (hazard),
                .flush     (flush),
                .stall     (stall),
                .ctrl_out  (ctrlOut[k]),
                .out_valid (outValid[k]),
`ifdef BUBBLE_CNT_EN
                .bubble_cnt(bubbleCnt[k]),
`endif
                .hold_up   (holdUp[k])
            );
        end
    endgenerate

    int vectors = 0;
    int miscompares = 0;

    // Reference model: each instance owes a number of bubbles (debt).
    int         mDebt [3];
    logic [9:0] mCtrl [3];
    logic       mValid [3];
    int         mCnt [3];
    logic       lastHold [3];

    typedef struct {
        logic [9:0] ci;
        logic       iv, h, f, s;
        logic [9:0] eCtrl;
        logic       eValid, eHold;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mDebt[k]  = 0;
            mCtrl[k]  = 10'h000;
            mValid[k] = 1'b0;
            mCnt[k]   = 0;
        end
    endtask

    // Drive one cycle's inputs, compare all instances, then advance the model.
    task automatic step(input logic [9:0] ci, input logic iv, input logic h,
                        input logic f, input logic s);
        @(negedge clk);
        ctrlIn = ci; inValid = iv; hazard = h; flush = f; stall = s;
        #1;
        for (int k = 0; k < 3; k++) begin
            logic eHold;
            eHold = s || (mDebt[k] > 0) || (h && !f);
            check($sformatf("ctrl[bc%0d]", k + 1), 32'(ctrlOut[k]), 32'(mCtrl[k]));
            check($sformatf("valid[bc%0d]", k + 1), 32'(outValid[k]), 32'(mValid[k]));
            check($sformatf("hold[bc%0d]", k + 1), 32'(holdUp[k]), 32'(eHold));
`ifdef BUBBLE_CNT_EN
            check($sformatf("cnt[bc%0d]", k + 1), 32'(bubbleCnt[k]), 32'(mCnt[k]));
`endif
            lastHold[k] = holdUp[k];
        end
        for (int k = 0; k < 3; k++) begin
            bit bubble;
            bubble = 1'b0;
            if (f) begin
                mCtrl[k] = 10'h000; mValid[k] = 1'b0; mDebt[k] = 0;
            end else if (s) begin
                // frozen
            end else if (mDebt[k] > 0) begin
                bubble = 1'b1; mDebt[k]--;
            end else if (h) begin
                bubble = 1'b1; mDebt[k] = k;   // BUBBLE_CYCLES - 1
            end else begin
                mCtrl[k] = ci; mValid[k] = iv;
            end
            if (bubble) begin
                mCtrl[k] = 10'h000; mValid[k] = 1'b0;
                if (mCnt[k] < 65535) mCnt[k]++;
            end
        end
    endtask

    initial begin
        int holdCycles;
`ifdef BUBBLE_CNT_EN
        logic [15:0] cntBefore;
`endif
        // Directed vectors; expectations are for the BUBBLE_CYCLES=2 instance.
        //            ci       iv    h     f     s     eCtrl    eV    eHold
        tbl[0]  = '{10'h155, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        tbl[1]  = '{10'h0AA, 1'b1, 1'b1, 1'b0, 1'b0, 10'h155, 1'b1, 1'b1};
        tbl[2]  = '{10'h0AA, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[3]  = '{10'h0AA, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        tbl[4]  = '{10'h123, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0AA, 1'b1, 1'b0};
        tbl[5]  = '{10'h077, 1'b1, 1'b1, 1'b1, 1'b0, 10'h123, 1'b0, 1'b0};
        tbl[6]  = '{10'h077, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        tbl[7]  = '{10'h2C3, 1'b1, 1'b0, 1'b0, 1'b1, 10'h077, 1'b1, 1'b1};
        tbl[8]  = '{10'h2C3, 1'b1, 1'b0, 1'b0, 1'b0, 10'h077, 1'b1, 1'b0};
        tbl[9]  = '{10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0, 10'h2C3, 1'b1, 1'b1};
        tbl[10] = '{10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1};
        tbl[11] = '{10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        tbl[12] = '{10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF, 1'b1, 1'b0};
        tbl[13] = '{10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};

        rst_n = 1'b0; ctrlIn = 10'h3FF; inValid = 1'b1;
        hazard = 1'b0; flush = 1'b0; stall = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        check("reset ctrl", 32'(ctrlOut[0]), 32'h0);
        check("reset valid", 32'(outValid[0]), 32'h0);
        check("reset hold", 32'(holdUp[0]), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].ci, tbl[i].iv, tbl[i].h, tbl[i].f, tbl[i].s);
            check($sformatf("tbl%0d ctrl", i), 32'(ctrlOut[1]), 32'(tbl[i].eCtrl));
            check($sformatf("tbl%0d valid", i), 32'(outValid[1]), 32'(tbl[i].eValid));
            check($sformatf("tbl%0d hold", i), 32'(holdUp[1]), 32'(tbl[i].eHold));
        end

        // Stall for two cycles right after the first bubble (BUBBLE_CYCLES=3).
`ifdef BUBBLE_CNT_EN
        cntBefore = bubbleCnt[2];
`endif
        holdCycles = 0;
        step(10'h0AA, 1'b1, 1'b1, 1'b0, 1'b0); holdCycles += int'(lastHold[2]);
        step(10'h0AA, 1'b1, 1'b0, 1'b0, 1'b1); holdCycles += int'(lastHold[2]);
        step(10'h0AA, 1'b1, 1'b0, 1'b0, 1'b1); holdCycles += int'(lastHold[2]);
        for (int i = 0; i < 4; i++) begin
            step(10'h0AA, 1'b1, 1'b0, 1'b0, 1'b0); holdCycles += int'(lastHold[2]);
        end
        check("stall-in-bubble hold cycles", 32'(holdCycles), 32'd5);
        check("stall-in-bubble output", 32'(ctrlOut[2]), 32'h0AA);
`ifdef BUBBLE_CNT_EN
        check("stall-in-bubble count", 32'(bubbleCnt[2] - cntBefore), 32'd3);
`endif

        // Asynchronous reset mid-bubble, asserted away from any clock edge.
        step(10'h111, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        hazard = 1'b0; stall = 1'b0; flush = 1'b0; ctrlIn = 10'h3FF;
        rst_n = 1'b0;
        #1;
        modelReset();
        check("async reset ctrl", 32'(ctrlOut[2]), 32'h0);
        check("async reset valid", 32'(outValid[2]), 32'h0);
        check("async reset hold", 32'(holdUp[2]), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(10'h155, 1'b1, 1'b0, 1'b0, 1'b0);
        step(10'h155, 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(10'($urandom), 1'($urandom), ($urandom_range(3) == 0),
                 ($urandom_range(9) == 0), ($urandom_range(5) == 0));
        end

`ifdef BUBBLE_CNT_EN
        // Drive continuous hazards until every counter saturates.
        for (int i = 0; i < 65540; i++) begin
            step(10'h0AA, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        step(10'h0AA, 1'b1, 1'b1, 1'b0, 1'b0);
        check("saturated count", 32'(bubbleCnt[0]), 32'h0000FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
